// File: rtl/spi_slave_responder.sv
// SPI responder: oversamples SCK/SS/MOSI in the PCLK domain, supports all four
// SPI modes, and streams MSB-first bytes in both directions with no inter-byte gap.
module spi_slave_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = 8'hFF
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       spe,
  input  logic [1:0] spi_mode,
  input  logic       sclk_in,
  input  logic       ss_in,
  input  logic       mosi_in,
  output logic       miso_out,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_q, ss_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic [1:0]             mode_q;
  logic [7:0]             tx_buf, shift_tx, shift_rx;
  logic [2:0]             bit_cnt;
  logic                   first_bit;

  logic       cpol, cpha;
  logic       sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic       sample_edge, shift_edge, ss_fall;
  logic [7:0] tx_src;
  logic       tx_starved;
  logic       load_tx, do_sample, do_shift, abort;

  // Idle level of SS is high so a deselected bus never looks like a falling edge.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      ss_q      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cpol        = mode_q[1];
  assign cpha        = mode_q[0];
  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;
  assign ss_fall     = ss_q & ~ss_s;

  // A tx_load coinciding with a reload feeds the shifter directly.
  assign tx_src     = tx_load ? tx_data : (tx_empty ? IDLE_TX : tx_buf);
  assign tx_starved = ~tx_load & tx_empty;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_next = state;
    load_tx    = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: if (spe && ss_fall) state_next = ARM;
      ARM: begin
        if (!spe || ss_s) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else begin
          state_next = SHIFT;
          load_tx    = 1'b1;
        end
      end
      SHIFT: begin
        if (!spe || ss_s) begin
          state_next = IDLE;
          abort      = 1'b1;
        end else begin
          do_sample = sample_edge;
          do_shift  = shift_edge;
          load_tx   = sample_edge && (bit_cnt == 3'd7);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Mode is frozen for the whole selected period.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                  mode_q <= 2'b00;
    else if (state == IDLE && ss_s) mode_q <= spi_mode;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      miso_out    <= 1'b0;
      miso_oe     <= 1'b0;
      tx_empty    <= 1'b1;
      tx_buf      <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      shift_tx    <= 8'h00;
      shift_rx    <= 8'h00;
      bit_cnt     <= 3'd0;
      first_bit   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      miso_oe   <= (state_next != IDLE);

      if (tx_load) begin
        tx_buf      <= tx_data;
        tx_underrun <= 1'b0;
      end
      if (load_tx)      tx_empty <= 1'b1;
      else if (tx_load) tx_empty <= 1'b0;

      // After a reload the next shift edge presents the new MSB instead of shifting.
      if (load_tx) begin
        shift_tx <= tx_src;
        if (tx_starved) tx_underrun <= 1'b1;
        if (state == ARM && !cpha) begin
          miso_out  <= tx_src[7];
          first_bit <= 1'b0;
        end else begin
          first_bit <= 1'b1;
        end
      end

      if (do_shift) begin
        if (first_bit) begin
          miso_out  <= shift_tx[7];
          first_bit <= 1'b0;
        end else begin
          shift_tx <= {shift_tx[6:0], 1'b0};
          miso_out <= shift_tx[6];
        end
      end

      if (do_sample) begin
        shift_rx <= {shift_rx[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_data  <= {shift_rx[6:0], mosi_s};
          rx_valid <= 1'b1;
        end
      end

      if (abort) frame_err <= (bit_cnt != 3'd0);

      if (state_next == IDLE) begin
        bit_cnt  <= 3'd0;
        shift_rx <= 8'h00;
        miso_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a bit-level SPI master drives frames while a
// monitor checks every received byte against a queue of expected bytes.
module tb_spi_slave_responder;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       spe = 1'b1;
  logic [1:0] spi_mode = 2'b00;
  logic       sclk_in = 1'b0;
  logic       ss_in = 1'b1;
  logic       mosi_in = 1'b0;
  logic       miso_out, miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, frame_err;

  always #5 PCLK = ~PCLK;

  spi_slave_responder dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .spe         (spe),
    .spi_mode    (spi_mode),
    .sclk_in     (sclk_in),
    .ss_in       (ss_in),
    .mosi_in     (mosi_in),
    .miso_out    (miso_out),
    .miso_oe     (miso_oe),
    .tx_data     (tx_data),
    .tx_load     (tx_load),
    .tx_empty    (tx_empty),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .frame_err   (frame_err)
  );

  int total = 0;
  int bad = 0;
  int ferr_seen = 0;
  logic [7:0] exp_rx[$];

  // Reference transmit buffer: one pending byte or none, plus the sticky underrun flag.
  logic       m_valid = 1'b0;
  logic [7:0] m_pend = 8'h00;
  logic       m_underrun = 1'b0;

  logic [7:0] f_mosi[4];
  logic       f_load[4];
  logic [7:0] f_lval[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  function automatic logic [7:0] model_take();
    if (m_valid) begin
      m_valid = 1'b0;
      return m_pend;
    end
    m_underrun = 1'b1;
    return 8'hFF;
  endfunction

  task automatic pulse_load(input logic [7:0] b);
    tx_data    = b;
    tx_load    = 1'b1;
    m_pend     = b;
    m_valid    = 1'b1;
    m_underrun = 1'b0;
    tick(1);
    tx_load = 1'b0;
  endtask

  // Monitor: every rx_valid pulse must match the oldest expected byte.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
        else                    check("rx_data", rx_data, exp_rx.pop_front());
      end
      if (frame_err) ferr_seen++;
    end
  end

  // One SS-low frame of nbits clocks; SCK half period is 4 PCLK cycles.
  task automatic run_frame(input logic [1:0] mode, input int nbits);
    logic [7:0] want_tx[4];
    logic [7:0] got_tx[4];
    logic       cpol, cpha;
    int         nfull, part, ferr0;
    cpol  = mode[1];
    cpha  = mode[0];
    nfull = nbits / 8;
    part  = nbits % 8;
    spi_mode = mode;
    sclk_in  = cpol;
    tick(6);
    for (int j = 0; j < 4; j++) begin
      got_tx[j]  = 8'h00;
      want_tx[j] = 8'h00;
    end
    for (int j = 0; j < nfull; j++) exp_rx.push_back(f_mosi[j]);
    ferr0 = ferr_seen;
    ss_in = 1'b0;
    if (!cpha) mosi_in = f_mosi[0][7];
    tick(8);
    spi_mode = 2'($urandom);
    for (int k = 0; k < nbits; k++) begin
      int j;
      int b;
      j = k / 8;
      b = 7 - (k % 8);
      if (k % 8 == 0) want_tx[j] = model_take();
      sclk_in = ~cpol;
      if (!cpha) got_tx[j][b] = miso_out;
      else       mosi_in = f_mosi[j][b];
      if (k == 0) check("miso_oe_active", miso_oe, 1'b1);
      if (k % 8 == 3 && f_load[j]) begin
        pulse_load(f_lval[j]);
        tick(3);
      end else begin
        tick(4);
      end
      sclk_in = cpol;
      if (cpha)              got_tx[j][b] = miso_out;
      else if (k + 1 < nbits) mosi_in = f_mosi[(k+1)/8][7-((k+1)%8)];
      tick(4);
    end
    if (part == 0) void'(model_take());
    ss_in = 1'b1;
    tick(8);
    spi_mode = mode;
    for (int j = 0; j < nfull; j++) check("miso_byte", got_tx[j], want_tx[j]);
    if (part != 0)
      check("miso_partial", got_tx[nfull] >> (8 - part), want_tx[nfull] >> (8 - part));
    if (nfull > 0) check("rx_data_held", rx_data, f_mosi[nfull-1]);
    check("rx_all_seen", exp_rx.size(), 0);
    check("frame_err_count", ferr_seen - ferr0, (part != 0) ? 1 : 0);
    check("miso_oe_idle", miso_oe, 1'b0);
    check("tx_underrun", tx_underrun, m_underrun);
    check("tx_empty", tx_empty, !m_valid);
  endtask

  task automatic clear_plan();
    for (int j = 0; j < 4; j++) begin
      f_mosi[j] = 8'h00;
      f_load[j] = 1'b0;
      f_lval[j] = 8'h00;
    end
  endtask

  initial begin
    tick(3);
    check("rst_miso_out", miso_out, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_tx_empty", tx_empty, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_underrun", tx_underrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    PRESET = 1'b0;
    tick(4);

    // Mode 0 basic exchange.
    clear_plan();
    pulse_load(8'hA5);
    f_mosi[0] = 8'h3C;
    run_frame(2'd0, 8);

    // Modes 1..3.
    for (int m = 1; m < 4; m++) begin
      clear_plan();
      pulse_load(8'h96);
      f_mosi[0] = 8'h69;
      run_frame(2'(m), 8);
    end

    // Back-to-back bytes with the second byte loaded mid-transfer.
    clear_plan();
    pulse_load(8'h11);
    f_mosi[0] = 8'hC3;
    f_mosi[1] = 8'h5A;
    f_load[0] = 1'b1;
    f_lval[0] = 8'h22;
    run_frame(2'd0, 16);

    // Underrun: nothing loaded, IDLE_TX goes out and the flag sticks until a load.
    clear_plan();
    f_mosi[0] = 8'h81;
    run_frame(2'd3, 8);
    check("underrun_sticky", tx_underrun, 1'b1);
    pulse_load(8'h7E);
    tick(1);
    check("underrun_cleared", tx_underrun, m_underrun);
    check("tx_empty_after_load", tx_empty, !m_valid);

    // SS raised after 5 bits, then a full byte.
    clear_plan();
    f_mosi[0] = 8'hF0;
    run_frame(2'd1, 5);
    clear_plan();
    pulse_load(8'h4B);
    f_mosi[0] = 8'hB4;
    run_frame(2'd1, 8);

    // Asynchronous reset in the middle of a byte.
    clear_plan();
    pulse_load(8'h5A);
    spi_mode = 2'd0;
    sclk_in  = 1'b0;
    tick(6);
    ss_in = 1'b0;
    mosi_in = 1'b1;
    tick(8);
    for (int e = 0; e < 3; e++) begin
      sclk_in = ~sclk_in;
      tick(4);
    end
    #3 PRESET = 1'b1;
    #1;
    check("arst_miso_out", miso_out, 1'b0);
    check("arst_miso_oe", miso_oe, 1'b0);
    check("arst_tx_empty", tx_empty, 1'b1);
    check("arst_rx_data", rx_data, 8'h00);
    check("arst_underrun", tx_underrun, 1'b0);
    check("arst_frame_err", frame_err, 1'b0);
    m_valid    = 1'b0;
    m_underrun = 1'b0;
    tick(2);
    PRESET  = 1'b0;
    ss_in   = 1'b1;
    sclk_in = 1'b0;
    tick(4);
    clear_plan();
    pulse_load(8'hE7);
    f_mosi[0] = 8'h18;
    run_frame(2'd2, 8);

    // Randomised frames.
    for (int t = 0; t < 24; t++) begin
      int nbytes, part;
      clear_plan();
      nbytes = int'($urandom_range(1, 3));
      part   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      for (int j = 0; j < 4; j++) begin
        f_mosi[j] = 8'($urandom);
        f_load[j] = 1'($urandom);
        f_lval[j] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) pulse_load(8'($urandom));
      run_frame(2'($urandom), nbytes * 8 + part);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

SPI slave (responder) for the far end of the bus driven by the APB SPI master core. It over-samples SCK, SS and MOSI in the PCLK domain and supports all four SPI modes. It deserialises MOSI into bytes and serialises a locally loaded transmit byte onto MISO, MSB first. It provides the loop-back partner the master's slave-select and baud logic is verified against.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth for sclk_in/ss_in/mosi_in (≥2)
- IDLE_TX, 8'hFF, byte shifted out when no tx byte is pending

Ports:
- PCLK  in  1  system clock; all logic on rising edge
- PRESET  in  1  asynchronous, active-high reset
- spe  in  1  slave enable; 0 forces IDLE, MISO tri-stated
- spi_mode  in  2  {CPOL,CPHA}; sampled only while ss_in high
- sclk_in  in  1  SPI clock from master (asynchronous)
- ss_in  in  1  slave select, active low (asynchronous)
- mosi_in  in  1  master-out data (asynchronous)
- miso_out  out  1  slave-out data
- miso_oe  out  1  MISO output enable (1 = drive)
- tx_data  in  8  next byte to transmit
- tx_load  in  1  one-cycle strobe capturing tx_data into tx buffer
- tx_empty  out  1  tx buffer empty
- rx_data  out  8  last complete received byte, held until next byte
- rx_valid  out  1  one-cycle pulse, rx_data updated
- tx_underrun  out  1  sticky; set when IDLE_TX used, cleared by tx_load
- frame_err  out  1  one-cycle pulse; SS rose mid-byte

## Operation
- Inputs pass SYNC_STAGES flops, then one register for edge detect; sclk lead edge = rising if CPOL=0, falling if CPOL=1; trail edge opposite.
- Sample edge: lead if CPHA=0, trail if CPHA=1. Shift (MISO update) edge: the other one.
- States: IDLE, ARM, SHIFT.
  - IDLE: miso_oe=0, bit_cnt=0. Synced ss falling and spe=1 -> ARM.
  - ARM (1 cycle): load shift_tx from tx buffer (or IDLE_TX if empty, setting tx_underrun); tx buffer -> empty; miso_oe=1; CPHA=0 drives MSB immediately. -> SHIFT.
  - SHIFT: on sample edge shift_rx <= {shift_rx[6:0], mosi}, bit_cnt+1 (3-bit, wraps 7->0). On shift edge shift_tx <<1, miso=new MSB; for CPHA=1 the first lead edge drives MSB without shifting. On 8th sample: rx_data <= completed byte, rx_valid pulse, reload shift_tx as in ARM so the next byte streams with no gap.
  - Synced ss high (any state) -> IDLE; if bit_cnt≠0 pulse frame_err, discard partial byte, no rx_valid.
- spe=0 -> IDLE next cycle, same abort rules.
- tx_load while tx_empty=0 overwrites the pending byte. tx_load in the same cycle as a reload: reload takes the new tx_data and tx_empty stays 1.
- spi_mode changes while ss low are ignored until IDLE.

## Timing
- Reset: miso_out=0, miso_oe=0, tx_empty=1, rx_data=8'h00, rx_valid=0, tx_underrun=0, frame_err=0, state IDLE, bit_cnt=0.
- Pin-to-internal latency: SYNC_STAGES+1 PCLK cycles. miso_out changes 1 cycle after the internal edge is detected.
- rx_valid asserts SYNC_STAGES+2 cycles after the 8th sampling pin edge.
- sclk_in high and low phases must each be ≥ SYNC_STAGES+2 PCLK cycles. Master BaudRateDivisor ≥ 2 (SCK period ≥ 8 PCLK) satisfies the default.
- ss_in low to first SCK edge: ≥ SYNC_STAGES+3 PCLK so ARM completes.

## Test plan
- Mode 0, tx_load 8'hA5, master sends 8'h3C over 8 SCK cycles (8 PCLK period) -> rx_data=8'h3C, one rx_valid pulse; master captures 8'hA5; tx_empty=1 afterward.
- Modes 1, 2, 3 each with tx 8'h96 / rx 8'h69 -> exact byte match both ways; MISO stable at every master sample edge.
- Two bytes, ss held low, second tx_load before byte 1 ends (8'h11, 8'h22) -> back-to-back rx_valid, MISO 8'h11 then 8'h22, no gap bits.
- No tx_load before SS falls -> MISO sends 8'hFF, tx_underrun=1 until next tx_load.
- SS raised after 5 bits -> frame_err pulse, no rx_valid, miso_oe=0; next full byte received correctly.
- PRESET asserted mid-byte -> all outputs reach reset values asynchronously; a transfer after release works.
